// File: rtl/t07_cpu_wb_bridge.sv
// CPU external-memory port to Wishbone classic bridge: one single-word bus cycle
// per CPU request, with a bounded ACK wait so busy_o always falls.
module t07_cpu_wb_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [1:0]  rwi_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic [31:0] inst_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  op_reg;
   logic [15:0] cnt_reg;
   logic [16:0] cnt_inc;
   logic        timeout;
   logic        busy_next;

   assign cnt_inc = {1'b0, cnt_reg} + 17'd1;
   assign timeout = (cnt_inc >= 17'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            busy_next = (rwi_i != 2'b00);
            if (rwi_i != 2'b00) state_next = BUS;
         end
         BUS: begin
            busy_next = 1'b1;
            if (wb_ack_i || timeout) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Gated by reset so busy drops the instant nrst falls, even with a request pending.
   assign busy_o = nrst & busy_next;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_reg   <= 2'b00;
         cnt_reg  <= 16'd0;
         inst_o   <= 32'd0;
         rdata_o  <= 32'd0;
         err_o    <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= 4'h0;
         wb_adr_o <= 32'd0;
         wb_dat_o <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rwi_i != 2'b00) begin
                  op_reg   <= rwi_i;
                  wb_adr_o <= addr_i;
                  wb_dat_o <= wdata_i;
                  wb_we_o  <= (rwi_i == 2'b10);
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_sel_o <= 4'hF;
                  err_o    <= 1'b0;
                  cnt_reg  <= 16'd0;
               end
            end
            BUS: begin
               // ACK takes precedence over a timeout on the same edge.
               if (wb_ack_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'h0;
                  if (op_reg == 2'b11)      inst_o  <= wb_dat_i;
                  else if (op_reg == 2'b01) rdata_o <= wb_dat_i;
               end else if (timeout) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= 4'h0;
                  err_o    <= 1'b1;
                  if (op_reg == 2'b11)      inst_o  <= ERR_DATA;
                  else if (op_reg == 2'b01) rdata_o <= ERR_DATA;
               end else if (cnt_reg != 16'hFFFF) begin
                  cnt_reg <= cnt_inc[15:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
